display_scheduler: RTL and testbench

Arbitrates between two value producers that want the 8-digit seven-segment display: the coprocessor scalar-result path and the debug/UART value path. Grants the display round-robin, latches the winning 30-bit value and drives the `display_top` control inputs (`result`, `data_ready`, `out_mode`, `disable_screen`). Each shown value is held for a minimum dwell time. The display blanks after an idle timeout or on an explicit clear.

---
 rtl/display_scheduler.sv | 131 +++++++++++++
 tb/tb_display_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Round-robin display arbiter: grants one of two value producers the seven-segment
// display, enforces a minimum dwell per value and blanks on idle timeout or clear.
module display_scheduler #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned IDLE_CYCLES  = 1_000_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [29:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [29:0] req1_data,
  output logic        req1_ready,
  input  logic        clear,
  output logic [29:0] result,
  output logic        data_ready,
  output logic        out_mode,
  output logic        disable_screen,
  output logic        src,
  output logic        busy
);

  localparam int NUM_REQ = 2;
  localparam int DW = (DWELL_CYCLES < 2) ? 1 : $clog2(DWELL_CYCLES + 1);
  localparam int IW = (IDLE_CYCLES  < 2) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX   = '1;

  typedef enum logic [2:0] {IDLE, LOAD, DWELL, HOLD, BLANK} state_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] data;
  } req_t;

  state_t               state, nxt;
  req_t   [NUM_REQ-1:0] req;
  logic   [NUM_REQ-1:0] rdy, acc;
  logic                 grant, last, open_win, any_acc;
  logic   [DW-1:0]      dwell_cnt, dwell_nxt;
  logic   [IW-1:0]      idle_cnt, idle_nxt;

  assign req[0] = '{valid: req0_valid, data: req0_data};
  assign req[1] = '{valid: req1_valid, data: req1_data};

  // Ties go to whoever was not served last; with no requests the pointer is held.
  always_comb begin
    grant = last;
    case ({req[1].valid, req[0].valid})
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = last;
    endcase
  end

  assign open_win = (state == IDLE || state == HOLD) && !clear && !rst;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign rdy[g] = open_win && (grant == 1'(g));
    assign acc[g] = rdy[g] && req[g].valid;
  end

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign any_acc    = |acc;

  always_comb begin
    nxt       = state;
    dwell_nxt = '0;
    idle_nxt  = '0;
    case (state)
      IDLE: begin
        if (clear)        nxt = BLANK;
        else if (any_acc) nxt = LOAD;
      end
      LOAD: begin
        if (clear) nxt = BLANK;
        else begin
          nxt       = DWELL;
          dwell_nxt = DWELL_LOAD;
        end
      end
      DWELL: begin
        if (clear)                 nxt = BLANK;
        else if (dwell_cnt == '0)  nxt = HOLD;
        else                       dwell_nxt = dwell_cnt - DW'(1);
      end
      HOLD: begin
        if (clear)        nxt = BLANK;
        else if (any_acc) nxt = LOAD;
        else if (IDLE_CYCLES != 0 && idle_cnt == IDLE_LAST) nxt = BLANK;
        else idle_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IW'(1);
      end
      BLANK:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dwell_cnt      <= '0;
      idle_cnt       <= '0;
      result         <= '0;
      src            <= 1'b0;
      last           <= 1'b1;
      data_ready     <= 1'b0;
      out_mode       <= 1'b0;
      busy           <= 1'b0;
      disable_screen <= 1'b1;
    end else begin
      state          <= nxt;
      dwell_cnt      <= dwell_nxt;
      idle_cnt       <= idle_nxt;
      data_ready     <= (nxt == LOAD);
      out_mode       <= (nxt == LOAD);
      busy           <= (nxt == LOAD) || (nxt == DWELL);
      disable_screen <= (nxt == BLANK);
      if (any_acc) begin
        result <= req[grant].data;
        src    <= grant;
        last   <= grant;
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with DWELL_CYCLES=4, IDLE_CYCLES=10.
module tb_display_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready, clear;
  logic [29:0] req0_data, req1_data, result;
  logic        data_ready, out_mode, disable_screen, src, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  display_scheduler #(.DWELL_CYCLES(4), .IDLE_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear(clear), .result(result), .data_ready(data_ready), .out_mode(out_mode),
    .disable_screen(disable_screen), .src(src), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_dr(input string tag, output int at);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!data_ready && n < 30);
    if (!data_ready) chk({tag, "_timeout"}, 32'd0, 32'd1);
    at = cyc;
  endtask

  int t0, t1, t2, k, bad;

  initial begin
    rst = 1'b1; clear = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;

    // 1. reset
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_blank", disable_screen, 1);
      chk("rst_rdy",   {req1_ready, req0_ready}, 0);
    end
    chk("rst_result", result, 0);
    chk("rst_dr",     data_ready, 0);
    chk("rst_busy",   busy, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_blank", disable_screen, 0);
    chk("idle_rdy_none", {req1_ready, req0_ready}, 2'b10);

    // 2. single value, dwell, auto-blank
    req0_valid = 1'b1; req0_data = 30'd123_456_789;
    #1 chk("idle_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("s_dr",     data_ready, 1);
    chk("s_mode",   out_mode, 1);
    chk("s_result", result, 123_456_789);
    chk("s_src",    src, 0);
    chk("s_rdy_k1", req0_ready, 0);
    chk("s_busy",   busy, 1);
    bad = 0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (req0_ready || data_ready) bad++;
    end
    chk("s_dwell_rdy_low", bad, 0);
    tick();
    chk("s_hold_rdy", req0_ready, 1);
    chk("s_hold_busy", busy, 0);
    bad = 0;
    for (int c = 7; c <= 15; c++) begin
      tick();
      if (disable_screen) bad++;
    end
    chk("s_no_early_blank", bad, 0);
    tick();
    chk("s_autoblank", disable_screen, 1);
    tick();
    chk("s_blank_1cyc", disable_screen, 0);
    chk("s_keep_result", result, 123_456_789);

    // 3. tie and round robin from a fresh pointer
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    req0_valid = 1'b1; req0_data = 30'd1;
    req1_valid = 1'b1; req1_data = 30'd1_000_000_000;
    wait_dr("rr0", t0);
    chk("rr0_src", src, 0); chk("rr0_res", result, 1);
    wait_dr("rr1", t1);
    chk("rr1_src", src, 1); chk("rr1_res", result, 1_000_000_000);
    chk("rr1_gap", t1 - t0, 6);
    wait_dr("rr2", t2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr2_src", src, 0); chk("rr2_res", result, 1);
    chk("rr2_gap", t2 - t1, 6);

    // 4. request raised during dwell waits for hold
    tick(); tick();
    req1_valid = 1'b1; req1_data = 30'd555;
    #1 chk("dw_rdy1_low", req1_ready, 0);
    wait_dr("dw", t0);
    req1_valid = 1'b0;
    chk("dw_gap", t0 - t2, 6);
    chk("dw_res", result, 555);
    chk("dw_src", src, 1);

    // 5. clear beats accept in hold
    for (int i = 0; i < 6; i++) tick();
    chk("cl_in_hold", busy, 0);
    req0_valid = 1'b1; req0_data = 30'd77; clear = 1'b1;
    #1 chk("cl_rdy_forced", req0_ready, 0);
    tick();
    clear = 1'b0;
    chk("cl_blank", disable_screen, 1);
    chk("cl_no_dr", data_ready, 0);
    chk("cl_keep_res", result, 555);
    tick();
    chk("cl_idle", disable_screen, 0);
    chk("cl_idle_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("cl_acc_dr", data_ready, 1);
    chk("cl_acc_res", result, 77);
    chk("cl_acc_src", src, 0);

    // 6. reset in the second dwell cycle
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("mr_result", result, 0);
    chk("mr_blank",  disable_screen, 1);
    chk("mr_dr",     data_ready, 0);
    chk("mr_busy",   busy, 0);
    rst = 1'b0;
    tick();
    chk("mr_idle_rdy", {req1_ready, req0_ready}, 2'b10);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_ready) k++;
    end
    chk("mr_no_stray_dr", k, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
